// File: rtl/stage_progress_tracker_pkg.sv
// Shared game definitions: stage encoding, default clear targets and
// the progress-tracker state encoding. Also imported by stage_controller.
package stage_progress_tracker_pkg;

    // Stage numbering as driven by the stage controller
    typedef enum logic [2:0] {
        INIT   = 3'd0,
        STAGE1 = 3'd1,
        STAGE2 = 3'd2,
        STAGE3 = 3'd3,
        STAGE4 = 3'd4
    } stage_e;

    // Progress tracker sequencing
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        PLAY     = 3'd2,
        CLEAR    = 3'd3,
        PULSE    = 3'd4,
        WAIT_ADV = 3'd5
    } tracker_state_e;

    // Default per-stage goals and banner length
    localparam int DEF_MONST_TARGET_S1 = 16;
    localparam int DEF_MONST_TARGET_S2 = 24;
    localparam int DEF_ASTERO_TARGET   = 20;
    localparam int DEF_BOSS_HP         = 20;
    localparam int DEF_CLEAR_FRAMES    = 60;

    // Width of the "targets left" counter shown on screen
    localparam int REMAINING_W = 6;

    // True for the four playable stages; INIT and unused codes are not
    function automatic logic isPlayStage(input logic [2:0] s);
        return (s >= STAGE1) && (s <= STAGE4);
    endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// Counts a fixed number of frame ticks after a start request and then
// holds done high until the next start. Usable by any timed banner.
module frame_delay_counter #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic resetN,
    input  logic start,
    input  logic tick,
    output logic done
);

    localparam int CW = (FRAMES < 2) ? 1 : $clog2(FRAMES + 1);
    localparam logic [CW-1:0] LAST = CW'((FRAMES > 0) ? (FRAMES - 1) : 0);

    logic [CW-1:0] count_q, count_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    // Next-state: start restarts the count (a zero-length delay is done at once)
    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (start) begin
            count_d = '0;
            busy_d  = (FRAMES != 0);
            done_d  = (FRAMES == 0);
        end else if (busy_q && tick) begin
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Counter registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/stage_progress_tracker.sv
// Tracks how many targets are left in the current stage, shows the
// "stage clear" banner for a number of frames and then pulses win_stage.
module stage_progress_tracker
    import stage_progress_tracker_pkg::*;
#(
    parameter int MONST_TARGET_S1 = DEF_MONST_TARGET_S1,
    parameter int MONST_TARGET_S2 = DEF_MONST_TARGET_S2,
    parameter int ASTERO_TARGET   = DEF_ASTERO_TARGET,
    parameter int BOSS_HP         = DEF_BOSS_HP,
    parameter int CLEAR_FRAMES    = DEF_CLEAR_FRAMES
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [2:0]             stage_num,
    input  logic                   enable_monst,
    input  logic                   enable_astero,
    input  logic                   enable_boss,
    input  logic                   monster_killed,
    input  logic                   astero_destroyed,
    input  logic                   boss_hit,
    output logic                   win_stage,
    output logic                   stage_clear,
    output logic [REMAINING_W-1:0] remaining
);

    tracker_state_e         state_q, state_d;
    logic [2:0]             stage_q, stage_d;
    logic [REMAINING_W-1:0] remaining_q, remaining_d;
    logic                   winStage_q, winStage_d;
    logic                   stageClear_q, stageClear_d;

    logic countPulse;
    logic stageChanged;
    logic frameStart;
    logic frameTick;
    logic frameDone;

    // Goal for a given stage; anything outside 1-4 has nothing to count
    function automatic logic [REMAINING_W-1:0] targetFor(input logic [2:0] s);
        logic [REMAINING_W-1:0] t;
        t = '0;
        case (s)
            STAGE1:  t = REMAINING_W'(MONST_TARGET_S1);
            STAGE2:  t = REMAINING_W'(MONST_TARGET_S2);
            STAGE3:  t = REMAINING_W'(ASTERO_TARGET);
            STAGE4:  t = REMAINING_W'(BOSS_HP);
            default: t = '0;
        endcase
        return t;
    endfunction

    // Pick the single event source that counts for the latched stage
    always_comb begin
        countPulse = 1'b0;
        case (stage_q)
            STAGE1, STAGE2: countPulse = monster_killed   && enable_monst;
            STAGE3:         countPulse = astero_destroyed && enable_astero;
            STAGE4:         countPulse = boss_hit         && enable_boss;
            default:        countPulse = 1'b0;
        endcase
    end

    assign stageChanged = (stage_num != stage_q);
    assign frameTick    = startOfFrame && (state_q == CLEAR);

    frame_delay_counter #(
        .FRAMES (CLEAR_FRAMES)
    ) u_frameDelay (
        .clk    (clk),
        .resetN (resetN),
        .start  (frameStart),
        .tick   (frameTick),
        .done   (frameDone)
    );

    // Next-state and registered-output decode; stage and goal are latched on entry to ARM
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        remaining_d  = remaining_q;
        winStage_d   = 1'b0;
        stageClear_d = stageClear_q;
        frameStart   = 1'b0;

        case (state_q)
            IDLE: begin
                stage_d      = '0;
                remaining_d  = '0;
                stageClear_d = 1'b0;
                if (isPlayStage(stage_num)) begin
                    state_d     = ARM;
                    stage_d     = stage_num;
                    remaining_d = targetFor(stage_num);
                end
            end

            ARM: begin
                state_d = PLAY;
            end

            PLAY: begin
                if (stageChanged) begin
                    stageClear_d = 1'b0;
                    if (isPlayStage(stage_num)) begin
                        state_d     = ARM;
                        stage_d     = stage_num;
                        remaining_d = targetFor(stage_num);
                    end else begin
                        state_d     = IDLE;
                        stage_d     = '0;
                        remaining_d = '0;
                    end
                end else if (remaining_q == '0) begin
                    state_d      = CLEAR;
                    stageClear_d = 1'b1;
                    frameStart   = 1'b1;
                end else if (countPulse) begin
                    remaining_d = remaining_q - 1'b1;
                end
            end

            CLEAR: begin
                if (stageChanged) begin
                    stageClear_d = 1'b0;
                    if (isPlayStage(stage_num)) begin
                        state_d     = ARM;
                        stage_d     = stage_num;
                        remaining_d = targetFor(stage_num);
                    end else begin
                        state_d     = IDLE;
                        stage_d     = '0;
                        remaining_d = '0;
                    end
                end else if (frameDone) begin
                    state_d      = PULSE;
                    winStage_d   = 1'b1;
                    stageClear_d = 1'b0;
                end
            end

            PULSE: begin
                state_d = WAIT_ADV;
            end

            WAIT_ADV: begin
                if (stageChanged) begin
                    if (isPlayStage(stage_num)) begin
                        state_d     = ARM;
                        stage_d     = stage_num;
                        remaining_d = targetFor(stage_num);
                    end else begin
                        state_d     = IDLE;
                        stage_d     = '0;
                        remaining_d = '0;
                    end
                end
            end

            default: begin
                state_d      = IDLE;
                stage_d      = '0;
                remaining_d  = '0;
                stageClear_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            remaining_q  <= '0;
            winStage_q   <= 1'b0;
            stageClear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            remaining_q  <= remaining_d;
            winStage_q   <= winStage_d;
            stageClear_q <= stageClear_d;
        end
    end

    assign win_stage   = winStage_q;
    assign stage_clear = stageClear_q;
    assign remaining   = remaining_q;

endmodule

// File: tb/tb_stage_progress_tracker.sv
// Directed testbench for stage_progress_tracker with default parameters.
module tb_stage_progress_tracker;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic [2:0] stage_num;
    logic       enable_monst;
    logic       enable_astero;
    logic       enable_boss;
    logic       monster_killed;
    logic       astero_destroyed;
    logic       boss_hit;
    logic       win_stage;
    logic       stage_clear;
    logic [5:0] remaining;

    int assertCount = 0;
    int failCount   = 0;
    int winCount    = 0;
    int winBase     = 0;

    stage_progress_tracker dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .stage_num        (stage_num),
        .enable_monst     (enable_monst),
        .enable_astero    (enable_astero),
        .enable_boss      (enable_boss),
        .monster_killed   (monster_killed),
        .astero_destroyed (astero_destroyed),
        .boss_hit         (boss_hit),
        .win_stage        (win_stage),
        .stage_clear      (stage_clear),
        .remaining        (remaining)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count win_stage cycles, sampled midway between rising edges
    always @(negedge clk) begin
        if (win_stage) winCount++;
    end

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle event pulses on the chosen sources
    task automatic applyStimulus(input logic m, input logic a, input logic b);
        monster_killed   = m;
        astero_destroyed = a;
        boss_hit         = b;
        step();
        monster_killed   = 1'b0;
        astero_destroyed = 1'b0;
        boss_hit         = 1'b0;
    endtask

    // Frame ticks: one-cycle pulse every three cycles
    task automatic sendFrames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step(2);
        end
    endtask

    initial begin
        resetN           = 1'b0;
        startOfFrame     = 1'b0;
        stage_num        = 3'd0;
        enable_monst     = 1'b0;
        enable_astero    = 1'b0;
        enable_boss      = 1'b0;
        monster_killed   = 1'b0;
        astero_destroyed = 1'b0;
        boss_hit         = 1'b0;
        step(3);
        checkOutput("rst_remaining", 32'(remaining), 32'd0);
        checkOutput("rst_clear", 32'(stage_clear), 32'd0);
        checkOutput("rst_win", 32'(win_stage), 32'd0);
        resetN = 1'b1;
        step(3);
        checkOutput("idle_remaining", 32'(remaining), 32'd0);

        // Stage 1: sixteen kills, banner, one win pulse after 60 frames
        stage_num = 3'd1;
        step();
        checkOutput("s1_load", 32'(remaining), 32'd16);
        step();
        enable_monst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("s1_count", 32'(remaining), 32'(16 - k));
        end
        step();
        checkOutput("s1_clear_on", 32'(stage_clear), 32'd1);
        checkOutput("s1_no_win_yet", 32'(winCount), 32'd0);
        sendFrames(59);
        checkOutput("s1_win_59", 32'(winCount), 32'd0);
        checkOutput("s1_clear_59", 32'(stage_clear), 32'd1);
        sendFrames(1);
        step(2);
        checkOutput("s1_win_60", 32'(winCount), 32'd1);
        checkOutput("s1_clear_off", 32'(stage_clear), 32'd0);

        // Stage number held at 1 in WAIT_ADV: no further wins
        step(20);
        sendFrames(5);
        checkOutput("hold_win", 32'(winCount), 32'd1);
        checkOutput("hold_remaining", 32'(remaining), 32'd0);
        checkOutput("hold_clear", 32'(stage_clear), 32'd0);

        // Stage 3: only asteroids count, one per cycle
        stage_num = 3'd3;
        step();
        checkOutput("s3_load", 32'(remaining), 32'd20);
        step();
        enable_astero = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("s3_simul", 32'(remaining), 32'd19);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_monst_ignored", 32'(remaining), 32'd19);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s3_astero", 32'(remaining), 32'd18);
        enable_astero = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("s3_gated", 32'(remaining), 32'd18);
        enable_astero = 1'b1;

        // Stage 4: boss hits saturate, exactly one win, then wrap to stage 1
        stage_num = 3'd4;
        step();
        checkOutput("s4_load", 32'(remaining), 32'd20);
        step();
        enable_boss = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s4_monst_ignored", 32'(remaining), 32'd20);
        for (int k = 0; k < 25; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s4_saturate", 32'(remaining), 32'd0);
        winBase = winCount;
        step();
        checkOutput("s4_clear_on", 32'(stage_clear), 32'd1);
        sendFrames(60);
        step(2);
        checkOutput("s4_one_win", 32'(winCount), 32'(winBase + 1));
        checkOutput("s4_clear_off", 32'(stage_clear), 32'd0);
        stage_num = 3'd1;
        step();
        checkOutput("wrap_reload", 32'(remaining), 32'd16);
        step();

        // Stage 2 aborted to INIT in the middle of the banner
        stage_num = 3'd2;
        step();
        checkOutput("s2_load", 32'(remaining), 32'd24);
        step();
        for (int k = 0; k < 24; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s2_zero", 32'(remaining), 32'd0);
        step();
        checkOutput("s2_clear_on", 32'(stage_clear), 32'd1);
        sendFrames(10);
        winBase = winCount;
        stage_num = 3'd0;
        step();
        checkOutput("abort_clear_off", 32'(stage_clear), 32'd0);
        checkOutput("abort_remaining", 32'(remaining), 32'd0);
        sendFrames(60);
        checkOutput("abort_no_win", 32'(winCount), 32'(winBase));
        checkOutput("abort_idle_clear", 32'(stage_clear), 32'd0);

        // Reset asserted at frame 30 of the banner
        stage_num = 3'd1;
        step();
        checkOutput("r_load", 32'(remaining), 32'd16);
        step();
        for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        step();
        checkOutput("r_clear_on", 32'(stage_clear), 32'd1);
        sendFrames(30);
        winBase = winCount;
        resetN = 1'b0;
        #1;
        checkOutput("r_remaining", 32'(remaining), 32'd0);
        checkOutput("r_clear", 32'(stage_clear), 32'd0);
        checkOutput("r_win", 32'(win_stage), 32'd0);
        step(2);
        checkOutput("r_hold_clear", 32'(stage_clear), 32'd0);
        resetN = 1'b1;
        step();
        checkOutput("r_reload", 32'(remaining), 32'd16);
        checkOutput("r_post_clear", 32'(stage_clear), 32'd0);
        step();
        sendFrames(61);
        checkOutput("r_no_win", 32'(winCount), 32'(winBase));
        checkOutput("r_still_16", 32'(remaining), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/stage_progress_tracker.md
STAGE_PROGRESS_TRACKER -- requirements
Module: stage_progress_tracker

Interface
REQ-001 The block SHALL have parameter MONST_TARGET_S1, default 16, meaning monster kills needed to clear stage 1.
REQ-002 The block SHALL have parameter MONST_TARGET_S2, default 24, meaning monster kills needed to clear stage 2.
REQ-003 The block SHALL have parameter ASTERO_TARGET, default 20, meaning asteroids destroyed to clear stage 3.
REQ-004 The block SHALL have parameter BOSS_HP, default 20, meaning boss hits needed to clear stage 4.
REQ-005 The block SHALL have parameter CLEAR_FRAMES, default 60, meaning banner duration in frames before win_stage.
REQ-006 The block SHALL have these ports:
- clk  in  1  system clock.
- resetN  in  1  reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- stage_num  in  3  current stage: 0 INIT, 1-4 STAGE1-4.
- enable_monst / enable_astero / enable_boss  in  1 each  stage enables from the stage controller.
- monster_killed / astero_destroyed / boss_hit  in  1 each  one-cycle event pulses.
- win_stage  out  1  one-cycle stage-complete pulse to the stage controller.
- stage_clear  out  1  high while the "stage clear" banner is shown.
- remaining  out  6  targets left in the current stage.
REQ-007 Reset SHALL be resetN, asynchronous, active-low; clock SHALL be clk.

Function
REQ-008 FSM states SHALL be IDLE, ARM, PLAY, CLEAR, PULSE, WAIT_ADV.
REQ-009 IDLE: stage_num==0; remaining=0; stage_num 1-4 -> ARM next cycle.
REQ-010 ARM (one cycle): latch stage_num; load remaining with S1/S2/ASTERO/BOSS_HP target for stages 1/2/3/4; -> PLAY.
REQ-011 PLAY: only the counting source SHALL decrement remaining by 1 per pulse: stage 1-2 monster_killed gated by enable_monst, stage 3 astero_destroyed gated by enable_astero, stage 4 boss_hit gated by enable_boss. Monster kills in stage 4 SHALL be ignored.
REQ-012 remaining SHALL saturate at 0; a pulse at 0 is ignored.
REQ-013 Simultaneous pulses from different sources SHALL count only the source matching the latched stage, at most 1 per cycle.
REQ-014 When remaining becomes 0, the FSM SHALL go PLAY -> CLEAR on the next cycle, clear the frame counter and assert stage_clear.
REQ-015 CLEAR: count startOfFrame pulses; after CLEAR_FRAMES pulses -> PULSE; event inputs ignored.
REQ-016 PULSE: win_stage=1 for exactly one cycle; stage_clear deasserts; -> WAIT_ADV.
REQ-017 WAIT_ADV: hold until stage_num differs from the latched value; new value 1-4 -> ARM (covers the 4->1 wrap); 0 -> IDLE.
REQ-018 In PLAY or CLEAR, a stage_num change SHALL abort to ARM (or IDLE if 0) without asserting win_stage.
REQ-019 If a target parameter is 0, the FSM SHALL go ARM -> PLAY -> CLEAR immediately.
REQ-020 Outputs SHALL be registered; win_stage asserts CLEAR_FRAMES frame ticks plus 2 cycles after the last counted kill.

Reset
REQ-021 On resetN low: state=IDLE, remaining=0, win_stage=0, stage_clear=0, frame counter=0, latched stage=0; this holds even mid-CLEAR.

Structure
REQ-022 The stage encoding enum (INIT..STAGE4 = 0..4) and default target constants SHALL live in the shared game package, also used by stage_controller.
REQ-023 The frame-delay count SHALL be a sub-module frame_delay_counter (start, tick, done) reusable by other timed banners.

Verification
REQ-024 The bench SHALL cover these scenarios:
- stage_num 0->1 then 16 monster_killed pulses -> remaining 16..0, stage_clear high, 60 frame ticks later one win_stage pulse.
- stage 3 with monster_killed and astero_destroyed in the same cycle -> remaining drops by 1 only.
- stage 4 with 25 boss_hit pulses -> remaining saturates at 0, exactly one win_stage; stage_num 4->1 -> remaining reloads to 16.
- stage_num 2->0 mid-CLEAR -> stage_clear drops, no win_stage, state IDLE.
- resetN low during CLEAR at frame 30 -> all outputs 0; after release with stage_num 1 -> remaining=16 after 1 cycle.
- win_stage held off while stage_num stays 1 in WAIT_ADV -> no second pulse.
